// File: rtl/ldm_stm_pkg.sv
// ldm_stm_pkg: shared types and constants for the LDM/STM block-transfer sequencer.
//   state_e   : sequencer FSM state (StWb exists only when WRITEBACK_EN is defined)
//   reg_idx_t : 4-bit register index
//   popcount  : number of set bits in a register list
package ldm_stm_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned REG_COUNT  = 16;

    typedef logic [3:0] reg_idx_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StXfer = 2'd1,
        StDone = 2'd2
`ifdef WRITEBACK_EN
        ,
        StWb   = 2'd3
`endif
    } state_e;

    function automatic logic [4:0] popcount(input logic [REG_COUNT-1:0] bits);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            cnt = cnt + 5'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lowest_bit_enc.sv
// lowest_bit_enc: combinational priority encoder selecting the lowest set bit.
//   bits  : input register list
//   idx   : index of the lowest set bit (0 when none)
//   valid : at least one bit is set
module lowest_bit_enc
    import ldm_stm_pkg::*;
(
    input  logic [REG_COUNT-1:0] bits,
    output reg_idx_t             idx,
    output logic                 valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = REG_COUNT - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx   = reg_idx_t'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: sequences an ARM-style LDM/STM block transfer, one register per cycle.
// Optional feature: define WRITEBACK_EN to add a one-cycle base-register writeback state.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start                      : request, sampled only in idle
//   is_load, up                : 1 = LDM / 0 = STM; 1 = increment-after / 0 = decrement-before
//   reg_list, base_addr, rn    : register list, base address, base register (writeback only)
//   busy, done                 : high during transfer/writeback; one-cycle completion pulse
//   rf_a1 / rf_rd1             : register file read port (STM source)
//   rf_a3, rf_wd3, rf_we3      : register file write port
//   mem_addr, mem_wd, mem_we   : data memory address, write data, write enable
//   mem_rd                     : data memory read data
module ldm_stm_sequencer
    import ldm_stm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_load,
    input  logic                 up,
    input  logic [REG_COUNT-1:0] reg_list,
    input  logic [31:0]          base_addr,
    input  logic [3:0]           rn,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           rf_a1,
    input  logic [31:0]          rf_rd1,
    output logic [3:0]           rf_a3,
    output logic [31:0]          rf_wd3,
    output logic                 rf_we3,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wd,
    output logic                 mem_we,
    input  logic [31:0]          mem_rd
);

    state_e               state_q, state_d;
    logic                 is_load_q;
    logic [REG_COUNT-1:0] list_q, list_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          span;
    logic                 accept;
    reg_idx_t             enc_idx;
    logic                 enc_valid;
    logic [REG_COUNT-1:0] remaining;

`ifdef WRITEBACK_EN
    logic [3:0]  rn_q;
    logic [31:0] wb_val_q;
    logic        wb_we_q;
`else
    logic unused_rn;
    assign unused_rn = ^rn;
`endif

    lowest_bit_enc u_enc (
        .bits  (list_q),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign accept    = (state_q == StIdle) && start;
    assign span      = 32'(popcount(reg_list)) * WORD_BYTES;
    assign remaining = list_q & ~(REG_COUNT'(1) << enc_idx);

    always_comb begin
        state_d  = state_q;
        list_d   = list_q;
        addr_d   = addr_q;
        busy     = 1'b0;
        done     = 1'b0;
        rf_a1    = '0;
        rf_a3    = '0;
        rf_wd3   = '0;
        rf_we3   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        mem_we   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    list_d  = reg_list;
                    // Decrement-before starts N words below base so addresses still ascend.
                    addr_d  = up ? base_addr : base_addr - span;
                    state_d = (|reg_list) ? StXfer : StDone;
                end
            end
            StXfer: begin
                busy = 1'b1;
                if (enc_valid) begin
                    mem_addr = addr_q;
                    if (is_load_q) begin
                        rf_a3  = enc_idx;
                        rf_wd3 = mem_rd;
                        rf_we3 = 1'b1;
                    end else begin
                        rf_a1  = enc_idx;
                        mem_wd = rf_rd1;
                        mem_we = 1'b1;
                    end
                    list_d = remaining;
                    addr_d = addr_q + WORD_BYTES;
                end
                if (!enc_valid || remaining == '0) begin
`ifdef WRITEBACK_EN
                    state_d = StWb;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef WRITEBACK_EN
            StWb: begin
                busy    = 1'b1;
                rf_a3   = rn_q;
                rf_wd3  = wb_val_q;
                rf_we3  = wb_we_q;
                state_d = StDone;
            end
`endif
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            is_load_q <= 1'b0;
            list_q    <= '0;
            addr_q    <= '0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            addr_q  <= addr_d;
            if (accept) begin
                is_load_q <= is_load;
            end
        end
    end

`ifdef WRITEBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rn_q     <= '0;
            wb_val_q <= '0;
            wb_we_q  <= 1'b0;
        end else if (accept) begin
            rn_q     <= rn;
            wb_val_q <= up ? base_addr + span : base_addr - span;
            // A load into the base register takes priority over the writeback.
            wb_we_q  <= !(is_load && reg_list[rn]);
        end
    end
`endif

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        up = 1'b0;
    logic [15:0] reg_list = '0;
    logic [31:0] base_addr = '0;
    logic [3:0]  rn = '0;
    logic        busy, done;
    logic [3:0]  rf_a1, rf_a3;
    logic [31:0] rf_rd1, rf_wd3, mem_addr, mem_wd, mem_rd;
    logic        rf_we3, mem_we;

    logic [31:0] rf_m [16];
    logic [31:0] mem_m [256];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ldm_stm_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_load   (is_load),
        .up        (up),
        .reg_list  (reg_list),
        .base_addr (base_addr),
        .rn        (rn),
        .busy      (busy),
        .done      (done),
        .rf_a1     (rf_a1),
        .rf_rd1    (rf_rd1),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3),
        .rf_we3    (rf_we3),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd)
    );

    // Register file and memory models (combinational read, clocked write).
    assign rf_rd1 = rf_m[rf_a1];
    assign mem_rd = mem_m[mem_addr[9:2]];

    always @(posedge clk) begin
        if (rf_we3) rf_m[rf_a3] <= rf_wd3;
        if (mem_we) mem_m[mem_addr[9:2]] <= mem_wd;
    end

    typedef struct {
        logic        is_load;
        logic        up;
        logic [15:0] list;
        logic [31:0] base;
        logic [3:0]  rn;
        int          n;
        logic [31:0] addr0;
        logic [31:0] wb_val;
        logic        wb_we;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " rf_we3"}, 32'(rf_we3), 32'd0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " rf_wd3"}, rf_wd3, 32'd0);
        chk({tag, " mem_wd"}, mem_wd, 32'd0);
    endtask

    // Runs one transfer; with scramble set, inputs and start are garbled while busy.
    task automatic run_vec(input vec_t v, input bit scramble);
        logic [15:0] rem;
        int          r;
        logic [31:0] a;
        rem = v.list;
        @(negedge clk);
        is_load   = v.is_load;
        up        = v.up;
        reg_list  = v.list;
        base_addr = v.base;
        rn        = v.rn;
        start     = 1'b1;
        @(negedge clk);
        for (int k = 0; k < v.n; k++) begin
            r = 0;
            for (int b = 0; b < 16; b++) begin
                if (rem[b]) begin
                    r = b;
                    break;
                end
            end
            rem[r] = 1'b0;
            a = v.addr0 + 32'(4 * k);
            chk("xfer busy", 32'(busy), 32'd1);
            chk("xfer done", 32'(done), 32'd0);
            chk("xfer mem_addr", mem_addr, a);
            if (v.is_load) begin
                chk("ldm rf_we3", 32'(rf_we3), 32'd1);
                chk("ldm mem_we", 32'(mem_we), 32'd0);
                chk("ldm rf_a3", 32'(rf_a3), 32'(r));
                chk("ldm rf_wd3", rf_wd3, mem_m[a[9:2]]);
            end else begin
                chk("stm mem_we", 32'(mem_we), 32'd1);
                chk("stm rf_we3", 32'(rf_we3), 32'd0);
                chk("stm rf_a1", 32'(rf_a1), 32'(r));
                chk("stm mem_wd", mem_wd, rf_m[r]);
            end
            if (scramble) begin
                start     = 1'b1;
                is_load   = ~v.is_load;
                up        = ~v.up;
                reg_list  = 16'($urandom);
                base_addr = $urandom;
                rn        = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
`ifdef WRITEBACK_EN
        if (v.n != 0) begin
            chk("wb busy", 32'(busy), 32'd1);
            chk("wb done", 32'(done), 32'd0);
            chk("wb rf_a3", 32'(rf_a3), 32'(v.rn));
            chk("wb rf_wd3", rf_wd3, v.wb_val);
            chk("wb rf_we3", 32'(rf_we3), 32'(v.wb_we));
            chk("wb mem_we", 32'(mem_we), 32'd0);
            @(negedge clk);
        end
`endif
        chk("done pulse", 32'(done), 32'd1);
        check_quiet("done");
        start = 1'b0;
        @(negedge clk);
        chk("idle done", 32'(done), 32'd0);
        check_quiet("idle");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf_m[i] = 32'h1000_0000 | 32'(i);
        for (int i = 0; i < 256; i++) mem_m[i] = 32'hA500_0000 | 32'(i);
        mem_m[64] = 32'h0000_000A;
        mem_m[65] = 32'h0000_000B;

        //          ld    up    list        base           rn  n   addr0          wb_val         wb_we
        vecs[0] = '{1'b1, 1'b1, 16'h0005, 32'h0000_0100, 4'd3, 2, 32'h0000_0100, 32'h0000_0108, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 16'h8002, 32'h0000_0200, 4'd13, 2, 32'h0000_01F8, 32'h0000_01F8, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 16'h00F0, 32'h0000_0300, 4'd5, 4, 32'h0000_02F0, 32'h0000_02F0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 32'h0000_0000, 4'd0, 16, 32'h0000_0000, 32'h0000_0040, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 16'h0000, 32'h0000_0080, 4'd1, 0, 32'h0000_0080, 32'h0000_0080, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 16'h0001, 32'h0000_0000, 4'd2, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 16'h8000, 32'hFFFF_FFFC, 4'd14, 1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 16'h0010, 32'h0000_0040, 4'd3, 1, 32'h0000_0040, 32'h0000_0044, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 16'h0006, 32'h0000_0080, 4'd2, 2, 32'h0000_0080, 32'h0000_0088, 1'b0};

        #1;
        chk("reset done", 32'(done), 32'd0);
        chk("reset rf_a1", 32'(rf_a1), 32'd0);
        chk("reset rf_a3", 32'(rf_a3), 32'd0);
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], (i % 2) == 1);
            if (i == 0) begin
                chk("ldm r0", rf_m[0], 32'h0000_000A);
                chk("ldm r2", rf_m[2], 32'h0000_000B);
            end
            if (i == 1) begin
                chk("stm mem 0x1F8", mem_m[126], 32'h1000_0001);
                chk("stm mem 0x1FC", mem_m[127], 32'h1000_000F);
            end
        end
        chk("r4 from 0x40", rf_m[4], 32'h0000_000B & 32'h0 | mem_m[16]);
`ifdef WRITEBACK_EN
        chk("wb r3", rf_m[3], 32'h0000_0044);
`else
        chk("no wb r3", rf_m[3], 32'h1000_0003);
`endif
        chk("loaded r2 kept", rf_m[2], 32'hA500_0021);

        // Reset during the second transfer of a 4-register STM.
        mem_m[97] = 32'hDEAD_BEEF;
        @(negedge clk);
        is_load   = 1'b0;
        up        = 1'b1;
        reg_list  = 16'h000F;
        base_addr = 32'h0000_0180;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst xfer1 mem_we", 32'(mem_we), 32'd1);
        chk("rst xfer1 addr", mem_addr, 32'h0000_0180);
        @(negedge clk);
        start = 1'b1;
        chk("rst xfer2 addr", mem_addr, 32'h0000_0184);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort no done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post-reset no done", 32'(done), 32'd0);
            chk("post-reset busy", 32'(busy), 32'd0);
        end
        chk("abort first stored", mem_m[96], rf_m[0]);
        chk("abort second kept", mem_m[97], 32'hDEAD_BEEF);

        mem_m[64] = 32'h0000_0055;
        mem_m[65] = 32'h0000_0066;
        run_vec(vecs[0], 1'b0);
        chk("after reset r0", rf_m[0], 32'h0000_0055);
        chk("after reset r2", rf_m[2], 32'h0000_0066);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-002 start  input  1  single-cycle request, sampled only in IDLE.
REQ-003 is_load  input  1  1 = LDM (memory to registers), 0 = STM (registers to memory).
REQ-004 up  input  1  1 = increment-after addressing, 0 = decrement-before addressing.
REQ-005 reg_list  input  16  bit i set = register i transferred.
REQ-006 base_addr  input  32  base address (Rn value).
REQ-007 rn  input  4  base register number; used only for writeback.
REQ-008 busy  output  1  high in XFER and WB.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 rf_a1  output  4  register file read address (STM source).
REQ-011 rf_rd1  input  32  register file read data, combinational from rf_a1.
REQ-012 rf_a3, rf_wd3, rf_we3  output  4/32/1  register file write address, data, enable.
REQ-013 mem_addr, mem_wd, mem_we  output  32/32/1  data memory address, write data, write enable.
REQ-014 mem_rd  input  32  data memory read data, combinational from mem_addr.

Function
REQ-015 On start in IDLE, the block SHALL latch is_load, up, reg_list, base_addr and rn; all later input changes SHALL be ignored until IDLE is re-entered.
REQ-016 States: IDLE, XFER, WB (WRITEBACK_EN only), DONE; start with a non-zero list goes IDLE->XFER, start with an all-zero list goes IDLE->DONE with no transfers.
REQ-017 XFER: exactly one register per cycle, lowest-numbered remaining bit first; that bit is cleared at the clock edge.
REQ-018 Start address: up=1 gives base_addr; up=0 gives base_addr - 4*N (N = popcount of the list); the address increments by 4 per transfer, so lower-numbered registers always map to lower addresses.
REQ-019 LDM cycle: mem_addr = current address, rf_a3 = current register, rf_wd3 = mem_rd, rf_we3 = 1, mem_we = 0.
REQ-020 STM cycle: rf_a1 = current register, mem_addr = current address, mem_wd = rf_rd1, mem_we = 1, rf_we3 = 0.
REQ-021 After the last set bit is transferred, the FSM goes XFER->WB if WRITEBACK_EN is defined, otherwise XFER->DONE.
REQ-022 DONE: done = 1 for exactly one cycle, busy = 0, no strobes; the next state is IDLE.
REQ-023 start SHALL be ignored in XFER, WB and DONE; a start in IDLE is accepted regardless of what happened in the previous cycle.
REQ-024 Outside the active transfer or writeback cycle, rf_we3 and mem_we SHALL be 0 and the address and data outputs SHALL be 0.
REQ-025 Address arithmetic is modulo 2^32; wrap-around SHALL NOT be flagged.
REQ-026 Bit 15 in the list is transferred like any other register; no special PC handling is done here.

Reset
REQ-027 With rst_n low, the block SHALL go to IDLE asynchronously, and busy, done, rf_we3, mem_we and all address and data outputs SHALL be 0.
REQ-028 A reset during XFER or WB SHALL abort the operation with no further strobes and no done pulse; transfers already performed are not undone.

Configuration
REQ-029 Macro WRITEBACK_EN: when defined, the WB state SHALL last one cycle, with rf_a3 = rn, rf_wd3 = base_addr + 4*N (up=1) or base_addr - 4*N (up=0), and rf_we3 = 1.
REQ-030 With WRITEBACK_EN defined, for an LDM whose list contains rn, the WB cycle SHALL still occur but with rf_we3 = 0, so the loaded value wins.
REQ-031 Without WRITEBACK_EN, the WB state and all writeback logic SHALL be absent, rn SHALL be ignored, and completion latency SHALL be N+1 cycles after start.

Structure
REQ-032 Package ldm_stm_pkg SHALL hold the state enum type, WORD_BYTES = 4, REG_COUNT = 16 and the register-index typedef (4-bit).
REQ-033 Sub-module lowest_bit_enc (16-bit input; 4-bit index and valid outputs; combinational) SHALL select the next register; popcount for N SHALL be a function in the package.

Verification
REQ-034 LDM, up=1, list=0x0005, base=0x100, mem[0x100]=0xA, mem[0x104]=0xB: r0=0xA in cycle 1, r2=0xB in cycle 2, done in cycle 3 (without macro).
REQ-035 STM, up=0, list=0x8002, base=0x200: r1 written to 0x1F8, r15 written to 0x1FC, mem_we high for exactly 2 cycles.
REQ-036 WRITEBACK_EN, LDM, up=1, list=0x0010, rn=3, base=0x40: r4 loaded from 0x40, then WB writes r3=0x44, then done.
REQ-037 WRITEBACK_EN, LDM, list includes rn=2: the WB cycle has rf_we3=0 and r2 keeps the loaded value.
REQ-038 list=0x0000: done pulses in the cycle after start, with no rf_we3 or mem_we activity.
REQ-039 rst_n low for the second transfer of a 4-register STM: strobes drop immediately, no done pulse, and a new start after reset works normally; a start pulsed during XFER has no effect.
